// File: rtl/sat_result_checker.sv
// Independent re-check of a claimed SAT model against the static clause store.
// One clause row is evaluated per cycle; reports a verdict plus the first failing row.
module sat_result_checker #(
  parameter int NUM_ROWS     = 32,
  parameter int COLS_PER_ROW = 4,
  parameter int NUM_VARS     = 16,
  parameter int LIT_WIDTH    = 6,
  localparam int AW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int CW = $clog2(NUM_ROWS + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              sat_claimed,
  input  logic [NUM_VARS:1]                 assigned,
  input  logic [NUM_VARS:1]                 values,
  output logic [AW-1:0]                     mem_addr,
  input  logic [COLS_PER_ROW*LIT_WIDTH-1:0] mem_row,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [1:0]                        fail_code,
  output logic [AW-1:0]                     fail_row,
  output logic [CW-1:0]                     rows_checked,
  output logic [1:0]                        dbg_state
);

  localparam int VW = LIT_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] FC_OK    = 2'b00;
  localparam logic [1:0] FC_FALSE = 2'b01;
  localparam logic [1:0] FC_OPEN  = 2'b10;
  localparam logic [1:0] FC_NOSAT = 2'b11;

  state_t              r_state, w_next;
  logic [NUM_VARS:1]   r_assigned, r_values;
  logic [AW-1:0]       r_addr, r_fail_row;
  logic [CW-1:0]       r_rows;
  logic                r_busy, r_done, r_pass, r_nosat_pend;
  logic [1:0]          r_fail_code;

  logic                w_any_true, w_any_open, w_all_empty;
  logic                w_row_ok, w_last, w_start_ok;
  logic [LIT_WIDTH-1:0] w_lit;
  logic [VW-1:0]       w_var;

  // start is a single-cycle request; it is accepted only outside SCAN
  // (IDLE or DONE) and has no ready/ack, a start during SCAN is dropped.
  assign w_start_ok = start && (r_state != SCAN);
  assign w_last     = (r_addr == AW'(NUM_ROWS - 1));

  // Unassigned or out-of-range variables are never true, only open.
  always_comb begin
    w_any_true  = 1'b0;
    w_any_open  = 1'b0;
    w_all_empty = 1'b1;
    w_lit       = '0;
    w_var       = '0;
    for (int c = 0; c < COLS_PER_ROW; c++) begin
      w_lit = mem_row[c*LIT_WIDTH +: LIT_WIDTH];
      w_var = w_lit[LIT_WIDTH-1:1];
      if (w_var != '0) begin
        w_all_empty = 1'b0;
        if (int'(w_var) <= NUM_VARS) begin
          if (r_assigned[w_var]) begin
            if (r_values[w_var] == w_lit[0]) w_any_true = 1'b1;
          end else begin
            w_any_open = 1'b1;
          end
        end else begin
          w_any_open = 1'b1;
        end
      end
    end
  end

  assign w_row_ok = w_any_true || w_all_empty;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_next = sat_claimed ? SCAN : DONE;
      SCAN:       if (!w_row_ok || w_last) w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_assigned   <= '0;
      r_values     <= '0;
      r_addr       <= '0;
      r_fail_row   <= '0;
      r_rows       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_code  <= FC_OK;
      r_nosat_pend <= 1'b0;
    end else if (w_start_ok) begin
      r_assigned   <= assigned;
      r_values     <= values;
      r_addr       <= '0;
      r_fail_row   <= '0;
      r_rows       <= '0;
      r_busy       <= sat_claimed;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_code  <= FC_OK;
      r_nosat_pend <= !sat_claimed;
    end else if (r_state == SCAN) begin
      r_rows <= r_rows + CW'(1);
      if (!w_row_ok) begin
        r_fail_code <= w_any_open ? FC_OPEN : FC_FALSE;
        r_fail_row  <= r_addr;
        r_busy      <= 1'b0;
        r_done      <= 1'b1;
      end else if (w_last) begin
        r_pass <= 1'b1;
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_addr <= r_addr + AW'(1);
      end
    end else if (r_nosat_pend) begin
      // Refused claim: verdict lands one cycle after the accepted start.
      r_fail_code  <= FC_NOSAT;
      r_done       <= 1'b1;
      r_nosat_pend <= 1'b0;
    end
  end

  assign mem_addr     = r_addr;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_pass;
  assign fail_code    = r_fail_code;
  assign fail_row     = r_fail_row;
  assign rows_checked = r_rows;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_sat_result_checker.sv
// Directed bench for sat_result_checker on a 4-row clause store:
// (x1|x2), (!x1|x3), pad, pad.
module tb_sat_result_checker;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int NV = 16;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          sat_claimed = 1'b0;
  logic [NV:1]   assigned = '0;
  logic [NV:1]   values = '0;
  logic [1:0]    mem_addr;
  logic [NC*LW-1:0] mem_row;
  logic          busy, done, pass;
  logic [1:0]    fail_code;
  logic [1:0]    fail_row;
  logic [2:0]    rows_checked;
  logic [1:0]    dbg_state;

  logic [NC*LW-1:0] mem [NR];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  logic busy_seen;

  assign mem_row = mem[mem_addr];

  sat_result_checker #(
    .NUM_ROWS(NR), .COLS_PER_ROW(NC), .NUM_VARS(NV), .LIT_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sat_claimed(sat_claimed),
    .assigned(assigned), .values(values), .mem_addr(mem_addr),
    .mem_row(mem_row), .busy(busy), .done(done), .pass(pass),
    .fail_code(fail_code), .fail_row(fail_row),
    .rows_checked(rows_checked), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one start pulse; returns just after the accepting edge.
  task automatic pulse_start(input logic sat, input logic [NV:1] a, input logic [NV:1] v);
    @(negedge clk);
    start = 1'b1; sat_claimed = sat; assigned = a; values = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count edges until done, starting from an already-elapsed count.
  task automatic wait_done(input int from, output int n);
    n = from;
    busy_seen = busy;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) busy_seen = 1'b1;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    // lit = {var, pol}; row = {s3, s2, s1, s0}
    mem[0] = {6'd0, 6'd0, 6'b000101, 6'b000011};  // x1 | x2
    mem[1] = {6'd0, 6'd0, 6'b000111, 6'b000010};  // !x1 | x3
    mem[2] = '0;
    mem[3] = '0;

    repeat (2) @(negedge clk);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_code", 32'(fail_code), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_rows", 32'(rows_checked), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst = 1'b0;

    // 1: x1=1, x3=1 -> all satisfied
    pulse_start(1'b1, 16'h0005, 16'h0005);
    check("t1_busy", 32'(busy), 1);
    wait_done(0, cyc);
    check("t1_cyc", 32'(cyc), 4);
    check("t1_pass", 32'(pass), 1);
    check("t1_code", 32'(fail_code), 0);
    check("t1_rows", 32'(rows_checked), 4);
    check("t1_addr", 32'(mem_addr), 3);
    check("t1_busy_end", 32'(busy), 0);

    // 2: x1=1, x3=0, all assigned -> row 1 false
    pulse_start(1'b1, 16'hFFFF, 16'h0001);
    check("t2_done_drop", 32'(done), 0);
    wait_done(0, cyc);
    check("t2_cyc", 32'(cyc), 2);
    check("t2_pass", 32'(pass), 0);
    check("t2_code", 32'(fail_code), 1);
    check("t2_row", 32'(fail_row), 1);
    check("t2_rows", 32'(rows_checked), 2);

    // 3: x1=1 assigned, x3 unassigned -> row 1 open
    pulse_start(1'b1, 16'h0001, 16'h0001);
    wait_done(0, cyc);
    check("t3_code", 32'(fail_code), 2);
    check("t3_row", 32'(fail_row), 1);
    check("t3_pass", 32'(pass), 0);

    // 4: refused SAT claim
    pulse_start(1'b0, 16'hFFFF, 16'hFFFF);
    wait_done(0, cyc);
    check("t4_cyc", 32'(cyc), 1);
    check("t4_code", 32'(fail_code), 3);
    check("t4_addr", 32'(mem_addr), 0);
    check("t4_busy_seen", 32'(busy_seen), 0);
    check("t4_rows", 32'(rows_checked), 0);
    check("t4_pass", 32'(pass), 0);

    // 5: reset while scanning row 2, then a full restart
    pulse_start(1'b1, 16'h0005, 16'h0005);
    repeat (2) @(negedge clk);
    check("t5_addr_mid", 32'(mem_addr), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_done", 32'(done), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_addr", 32'(mem_addr), 0);
    check("t5_rows", 32'(rows_checked), 0);
    check("t5_code", 32'(fail_code), 0);
    check("t5_state", 32'(dbg_state), 0);
    pulse_start(1'b1, 16'h0005, 16'h0005);
    wait_done(0, cyc);
    check("t5_re_cyc", 32'(cyc), 4);
    check("t5_re_pass", 32'(pass), 1);

    // 6: mid-scan model change and start pulse are ignored
    pulse_start(1'b1, 16'h0005, 16'h0005);
    @(negedge clk);
    start = 1'b1; sat_claimed = 1'b0; assigned = '0; values = '0;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, cyc);
    check("t6_cyc", 32'(cyc), 4);
    check("t6_pass", 32'(pass), 1);
    check("t6_code", 32'(fail_code), 0);
    check("t6_rows", 32'(rows_checked), 4);
    pulse_start(1'b1, 16'hFFFF, 16'h0001);
    check("t6_done_drop", 32'(done), 0);
    wait_done(0, cyc);
    check("t6_re_code", 32'(fail_code), 1);
    check("t6_re_cyc", 32'(cyc), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
